// File: rtl/uart_tx_if.sv
// Word-level handshake and serial line of the UART transmitter.
// The producer owns start/din; the transmitter owns ready, the line and status.
interface uart_tx_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic              dout;
  logic              busy;
  logic              done;

  modport master (
    output start, din,
    input  ready, dout, busy, done
  );

  modport slave (
    input  start, din,
    output ready, dout, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// 16-bit UART transmitter: start bit, 16 data bits LSB first, stop bit.
// A one-word holding register in front of the shifter lets the next word
// queue while a frame is on the line, so chained frames leave no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 435
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int DATA_W = 16;
  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [15:0]         cnt;
  logic [3:0]          bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   hold;
  logic                hold_vld;
  logic                dout_r;
  logic                busy_r;
  logic                done_r;

  logic                bit_end;
  logic                accept;
  logic                shifter_free;

  // Handshake decode: a word is taken whenever the holding register is empty;
  // it bypasses the holding register if the shifter is free on this edge.
  always_comb begin
    bit_end      = (cnt == CNT_MAX);
    accept       = bus.start && !hold_vld;
    shifter_free = (state == IDLE) || (state == STOP && bit_end && !hold_vld);
  end

  assign bus.ready = !hold_vld;
  assign bus.dout  = dout_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

  // Frame sequencer, holding register and registered line/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      dout_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // Shifter occupied: park the word until the current stop bit ends.
      if (accept && !shifter_free) begin
        hold     <= bus.din;
        hold_vld <= 1'b1;
      end

      case (state)
        IDLE: begin
          dout_r <= 1'b1;
          busy_r <= 1'b0;
          if (accept) begin
            shreg   <= bus.din;
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            dout_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
            dout_r  <= shreg[0];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 4'd15) begin
              state  <= STOP;
              dout_r <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              dout_r  <= shreg[bit_idx + 4'd1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            done_r  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            if (hold_vld) begin
              // Queued word follows immediately with its start bit.
              shreg    <= hold;
              hold_vld <= 1'b0;
              state    <= START;
              dout_r   <= 1'b0;
            end else if (accept) begin
              // New word arriving on the final stop edge goes straight out.
              shreg  <= bus.din;
              state  <= START;
              dout_r <= 1'b0;
            end else begin
              state  <= IDLE;
              dout_r <= 1'b1;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          bit_idx <= '0;
          dout_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast instance (4 clocks/bit) under random traffic and
// the default instance (435 clocks/bit) through the directed scenarios.
// The reference model keeps a list of frames (accept edge, first line edge,
// word) and derives the expected line and status from plain arithmetic.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  uart_tx_if if4 ();
  uart_tx_if if435 ();

  assign if4.start   = start && !sel;
  assign if4.din     = din;
  assign if435.start = start && sel;
  assign if435.din   = din;

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  uart_tx dut435 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if435.slave)
  );

  wire o_dout  = sel ? if435.dout  : if4.dout;
  wire o_busy  = sel ? if435.busy  : if4.busy;
  wire o_done  = sel ? if435.done  : if4.done;
  wire o_ready = sel ? if435.ready : if4.ready;

  int C = 4;
  int ek = 0;
  int n_chk = 0;
  int n_fail = 0;

  int          m_acc[$];
  int          m_st[$];
  logic [15:0] m_w[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: observed %0h, expected %0h", tag, ek, obs, exp);
    end
  endtask

  // Holding register occupied just before edge t.
  function automatic bit m_hold_pre(input int t);
    foreach (m_st[i])
      if (m_acc[i] < t && t <= m_st[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Edge at which the last scheduled frame completes its stop bit.
  function automatic int m_end();
    if (m_st.size() == 0) return 0;
    return m_st[m_st.size() - 1] + 18 * C;
  endfunction

  task automatic model_accept(input int t, input logic [15:0] w);
    int e;
    e = m_end();
    m_acc.push_back(t);
    m_st.push_back((e <= t) ? t : e);
    m_w.push_back(w);
  endtask

  task automatic model_clear();
    m_acc.delete();
    m_st.delete();
    m_w.delete();
  endtask

  task automatic check_edge();
    logic ed, eb, edn, er;
    ed = 1'b1; eb = 1'b0; edn = 1'b0; er = 1'b1;
    foreach (m_st[i]) begin
      int rel;
      int b;
      logic [15:0] w;
      rel = ek - m_st[i];
      w   = m_w[i];
      if (rel >= 0 && rel < 18 * C) begin
        eb = 1'b1;
        b  = rel / C;
        if (b == 0)       ed = 1'b0;
        else if (b <= 16) ed = w[b - 1];
        else              ed = 1'b1;
      end
      if (rel == 18 * C) edn = 1'b1;
      if (m_acc[i] <= ek && ek < m_st[i]) er = 1'b0;
    end
    chk("dout", 32'(o_dout), 32'(ed));
    chk("busy", 32'(o_busy), 32'(eb));
    chk("done", 32'(o_done), 32'(edn));
    chk("ready", 32'(o_ready), 32'(er));
  endtask

  task automatic step();
    int t;
    t = ek + 1;
    if (rst_n && start && !m_hold_pre(t)) model_accept(t, din);
    @(posedge clk);
    ek = t;
    #1;
    check_edge();
  endtask

  task automatic write(input logic [15:0] w);
    start = 1'b1;
    din   = w;
    step();
    start = 1'b0;
    din   = 16'($urandom);
  endtask

  // Step until the next step() lands on edge t.
  task automatic wait_to(input int t);
    if (t <= ek) chk("sched", 32'(ek), 32'(t - 1));
    while (ek < t - 1) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int e;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // 4 clocks/bit: 0x00FF frame lasts 72 cycles
    write(16'h00FF);
    s = m_st[m_st.size() - 1];
    wait_to(s + 72);
    chk("busy_last_stop", 32'(o_busy), 32'd1);
    step();
    chk("done_at_72", 32'(o_done), 32'd1);
    step();
    chk("idle_after_72", 32'(o_busy), 32'd0);

    // Random traffic including strobes while full and on stop edges
    repeat (1500) begin
      start = ($urandom_range(0, 7) == 0);
      din   = 16'($urandom);
      step();
    end
    start = 1'b0;
    repeat (200) step();

    // Switch to the 435 clocks/bit instance
    model_clear();
    C   = 435;
    sel = 1'b1;
    repeat (2) step();

    // Single word
    write(16'hA5C3);
    s = m_st[m_st.size() - 1];
    wait_to(s + 7830);
    step();
    chk("single_done", 32'(o_done), 32'd1);
    step();

    // Back-to-back, overflow, bypass on the done edge
    write(16'h0001);
    repeat (99) step();
    write(16'hFFFF);
    chk("b2b_ready_low", 32'(o_ready), 32'd0);
    repeat (10) step();
    write(16'h1234);
    chk("ovf_ready_low", 32'(o_ready), 32'd0);
    e = m_end();
    wait_to(e);
    start = 1'b1;
    din   = 16'h8000;
    step();
    start = 1'b0;
    din   = 16'($urandom);
    chk("byp_done", 32'(o_done), 32'd1);
    chk("byp_busy", 32'(o_busy), 32'd1);
    chk("byp_start_bit", 32'(o_dout), 32'd0);
    wait_to(m_end() + 2);
    step();

    // Reset during data bit 7 with a word queued
    write(16'h3C3C);
    s = m_st[m_st.size() - 1];
    repeat (50) step();
    write(16'h0F0F);
    wait_to(s + 8 * C + 200);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_dout", 32'(o_dout), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    model_clear();
    repeat (5) step();
    rst_n = 1'b1;
    repeat (3) step();
    write(16'h5A5A);
    wait_to(m_end() + 5);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
